// File: rtl/selfcheck_ctrl.sv
// Post-run self-check sequencer: waits for the core to halt (bounded by a timeout), scans
// the register file and then data memory, and latches one pass/fail verdict with its cause.
module selfcheck_ctrl #(
  parameter int          NUM_REGS       = 32,
  parameter int          NUM_WORDS      = 4,
  parameter logic [31:0] DM_BASE        = 32'h0000_1000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       core_halt,
  output logic [4:0]                 rf_raddr,
  input  logic [31:0]                rf_rdata,
  input  logic [NUM_REGS-1:0][31:0]  exp_rf,
  output logic                       dm_req,
  output logic [31:0]                dm_addr,
  input  logic                       dm_ack,
  input  logic                       dm_rvalid,
  input  logic [31:0]                dm_rdata,
  input  logic [NUM_WORDS-1:0][31:0] exp_dm,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [1:0]                 fail_code,
  output logic [31:0]                fail_index
);

  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int DW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_RF   = 2'd1;
  localparam logic [1:0] CODE_DM   = 2'd2;
  localparam logic [1:0] CODE_TO   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_HALT,
    S_SCAN_RF,
    S_DM_ISSUE,
    S_DM_WAIT,
    S_DONE
  } state_t;

  state_t         state, state_n;
  logic [RW-1:0]  rf_idx, rf_idx_n;
  logic [DW-1:0]  dm_idx, dm_idx_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           pass_n;
  logic [1:0]     code_n;
  logic [31:0]    findex_n;
  logic           dm_take;
  logic           dm_match;
  logic [31:0]    word_addr;

  assign dm_match  = (dm_rdata == exp_dm[dm_idx]);
  assign word_addr = DM_BASE + (32'(dm_idx) << 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rf_idx     <= '0;
      dm_idx     <= '0;
      cnt        <= '0;
      pass       <= 1'b0;
      fail_code  <= CODE_NONE;
      fail_index <= '0;
    end else begin
      state      <= state_n;
      rf_idx     <= rf_idx_n;
      dm_idx     <= dm_idx_n;
      cnt        <= cnt_n;
      pass       <= pass_n;
      fail_code  <= code_n;
      fail_index <= findex_n;
    end
  end

  // A memory response is consumed either in the ack cycle (zero-wait memory) or later in S_DM_WAIT.
  always_comb begin
    state_n  = state;
    rf_idx_n = rf_idx;
    dm_idx_n = dm_idx;
    cnt_n    = cnt;
    pass_n   = pass;
    code_n   = fail_code;
    findex_n = fail_index;
    dm_take  = 1'b0;
    dm_req   = 1'b0;
    dm_addr  = '0;
    rf_raddr = '0;
    busy     = (state != S_IDLE) && (state != S_DONE);
    done     = (state == S_DONE);

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_WAIT_HALT;
          cnt_n   = '0;
        end
      end
      S_WAIT_HALT: begin
        if (core_halt) begin
          state_n  = S_SCAN_RF;
          rf_idx_n = '0;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_n = S_DONE;
          code_n  = CODE_TO;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_SCAN_RF: begin
        rf_raddr = 5'(rf_idx);
        if (rf_rdata != exp_rf[rf_idx]) begin
          state_n  = S_DONE;
          code_n   = CODE_RF;
          findex_n = 32'(rf_idx);
        end else if (rf_idx == RW'(NUM_REGS - 1)) begin
          state_n  = S_DM_ISSUE;
          dm_idx_n = '0;
        end else begin
          rf_idx_n = rf_idx + 1'b1;
        end
      end
      S_DM_ISSUE: begin
        dm_req  = 1'b1;
        dm_addr = word_addr;
        if (dm_ack) begin
          if (dm_rvalid) dm_take = 1'b1;
          else           state_n = S_DM_WAIT;
        end
      end
      S_DM_WAIT: begin
        if (dm_rvalid) dm_take = 1'b1;
      end
      S_DONE: begin
        if (start) begin
          state_n  = S_WAIT_HALT;
          cnt_n    = '0;
          pass_n   = 1'b0;
          code_n   = CODE_NONE;
          findex_n = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (dm_take) begin
      if (!dm_match) begin
        state_n  = S_DONE;
        code_n   = CODE_DM;
        findex_n = 32'(dm_idx);
      end else if (dm_idx == DW'(NUM_WORDS - 1)) begin
        state_n = S_DONE;
        pass_n  = 1'b1;
      end else begin
        state_n  = S_DM_ISSUE;
        dm_idx_n = dm_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_selfcheck_ctrl.sv
// Bench for selfcheck_ctrl: table vectors plus randomized runs checked against a scan model,
// and hand-written sequences for timeout, reset during a memory wait, and restart.
module tb_selfcheck_ctrl;

  localparam int          NR   = 32;
  localparam int          NW   = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic                 clk = 1'b0;
  logic                 rst, start, core_halt;
  logic [4:0]           rf_raddr;
  logic [31:0]          rf_rdata;
  logic [NR-1:0][31:0]  exp_rf;
  logic                 dm_req;
  logic [31:0]          dm_addr;
  logic                 dm_ack, dm_rvalid;
  logic [31:0]          dm_rdata;
  logic [NW-1:0][31:0]  exp_dm;
  logic                 busy, done, pass;
  logic [1:0]           fail_code;
  logic [31:0]          fail_index;

  logic [4:0]  t_rf_raddr;
  logic [31:0] t_rf_rdata;
  logic        t_dm_req;
  logic [31:0] t_dm_addr;
  logic        t_busy, t_done, t_pass;
  logic [1:0]  t_fail_code;
  logic [31:0] t_fail_index;

  logic [31:0] rf_mem [NR];
  logic [31:0] dm_mem [NW];
  logic [31:0] gold_rf [NR];
  logic [31:0] gold_dm [NW];

  assign rf_rdata   = rf_mem[rf_raddr];
  assign t_rf_rdata = rf_mem[t_rf_raddr];

  always #5 clk = ~clk;

  selfcheck_ctrl #(.NUM_REGS(NR), .NUM_WORDS(NW), .DM_BASE(BASE), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .core_halt(core_halt),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .exp_rf(exp_rf),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_ack(dm_ack), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata), .exp_dm(exp_dm),
    .busy(busy), .done(done), .pass(pass), .fail_code(fail_code), .fail_index(fail_index)
  );

  // Short-timeout instance; its memory port never answers, only the wait-for-halt path matters.
  selfcheck_ctrl #(.NUM_REGS(NR), .NUM_WORDS(NW), .DM_BASE(BASE), .TIMEOUT_CYCLES(16)) dut_to (
    .clk(clk), .rst(rst), .start(start), .core_halt(core_halt),
    .rf_raddr(t_rf_raddr), .rf_rdata(t_rf_rdata), .exp_rf(exp_rf),
    .dm_req(t_dm_req), .dm_addr(t_dm_addr), .dm_ack(1'b0), .dm_rvalid(1'b0),
    .dm_rdata(32'h0), .exp_dm(exp_dm),
    .busy(t_busy), .done(t_done), .pass(t_pass), .fail_code(t_fail_code), .fail_index(t_fail_index)
  );

  typedef struct {
    string       name;
    int          halt_delay;
    int          ack_d;
    int          rv_d;
    int          kind;
    int          cidx;
    logic [31:0] cval;
    logic        exp_pass;
    logic [1:0]  exp_code;
    logic [31:0] exp_index;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          ack_delay = 0;
  int          rv_delay = 0;
  int          late_req = 0;
  int          late_done = 0;
  int          unstable_cnt = 0;
  logic [31:0] addr_log [$];

  // Memory model: acks after ack_delay request cycles, returns data rv_delay cycles later.
  initial begin : responder
    int          ack_wait, rv_wait, widx;
    bit          pending, prev_unacked;
    logic [31:0] pend_addr, prev_addr;
    ack_wait = 0; rv_wait = 0; pending = 0; prev_unacked = 0;
    pend_addr = '0; prev_addr = '0;
    dm_ack = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
    forever begin
      @(negedge clk); #1;
      dm_ack = 1'b0;
      dm_rvalid = 1'b0;
      if (rst) begin
        pending = 0; ack_wait = 0; prev_unacked = 0;
      end else begin
        if (late_req != late_done) begin
          dm_rvalid = 1'b1;
          dm_rdata  = dm_mem[0];
          late_done = late_req;
        end
        if (dm_req && prev_unacked && dm_addr != prev_addr) unstable_cnt++;
        if (dm_req && !pending) begin
          if (ack_wait >= ack_delay) begin
            dm_ack = 1'b1;
            ack_wait = 0;
            addr_log.push_back(dm_addr);
            pend_addr = dm_addr;
            if (rv_delay == 0) begin
              widx = int'((pend_addr - BASE) >> 2);
              dm_rvalid = 1'b1;
              dm_rdata  = (widx >= 0 && widx < NW) ? dm_mem[widx] : 32'hBAD0_BAD0;
            end else begin
              pending = 1; rv_wait = 0;
            end
          end else begin
            ack_wait++;
          end
        end else if (pending) begin
          rv_wait++;
          if (rv_wait >= rv_delay) begin
            widx = int'((pend_addr - BASE) >> 2);
            dm_rvalid = 1'b1;
            dm_rdata  = (widx >= 0 && widx < NW) ? dm_mem[widx] : 32'hBAD0_BAD0;
            pending = 0;
          end
        end
        prev_unacked = dm_req && !dm_ack;
        prev_addr    = dm_addr;
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("[TB] FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; core_halt = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic setBaseGold();
    for (int i = 0; i < NR; i++) gold_rf[i] = '0;
    gold_rf[1] = 32'h14; gold_rf[2] = 32'h3; gold_rf[3] = 32'h2; gold_rf[4] = 32'h6;
    gold_dm[0] = 32'h14; gold_dm[1] = 32'h3; gold_dm[2] = 32'h2; gold_dm[3] = 32'h6;
  endtask

  task automatic loadData(input vec_t v);
    for (int i = 0; i < NR; i++) begin rf_mem[i] = gold_rf[i]; exp_rf[i] = gold_rf[i]; end
    for (int i = 0; i < NW; i++) begin dm_mem[i] = gold_dm[i]; exp_dm[i] = gold_dm[i]; end
    if (v.kind == 1)      rf_mem[v.cidx] = v.cval;
    else if (v.kind == 2) dm_mem[v.cidx] = v.cval;
  endtask

  // Verdict = first differing register, else first differing memory word, else pass.
  task automatic refModel(output logic [1:0] code, output logic [31:0] idx);
    bit found = 0;
    code = 2'd0; idx = '0;
    for (int i = 0; i < NR; i++)
      if (!found && rf_mem[i] != exp_rf[i]) begin found = 1; code = 2'd1; idx = i; end
    for (int i = 0; i < NW; i++)
      if (!found && dm_mem[i] != exp_dm[i]) begin found = 1; code = 2'd2; idx = i; end
  endtask

  function automatic int expLatency(input logic [1:0] code, input logic [31:0] idx, input int ack_d, input int rv_d);
    int per_word = ack_d + 1 + rv_d;
    if (code == 2'd1) return int'(idx) + 1;
    if (code == 2'd2) return NR + (int'(idx) + 1) * per_word;
    return NR + NW * per_word;
  endfunction

  task automatic applyStimulus(input vec_t v, input bit with_reset, input int busy_pulse_at);
    int cyc, log_base, unst_base, nexp;
    if (with_reset) doReset();
    ack_delay = v.ack_d;
    rv_delay  = v.rv_d;
    log_base  = addr_log.size();
    unst_base = unstable_cnt;
    @(negedge clk); start = 1'b1; core_halt = 1'b0;
    @(negedge clk); start = 1'b0;
    checkOutput({v.name, "/start_busy"}, busy, 1);
    checkOutput({v.name, "/start_done"}, done, 0);
    checkOutput({v.name, "/start_pass"}, pass, 0);
    checkOutput({v.name, "/start_code"}, fail_code, 0);
    checkOutput({v.name, "/start_index"}, fail_index, 0);
    repeat (v.halt_delay - 1) @(negedge clk);
    core_halt = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!done && cyc < 3000) begin
      start = (cyc == busy_pulse_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checkOutput({v.name, "/done"}, done, 1);
    checkOutput({v.name, "/busy"}, busy, 0);
    checkOutput({v.name, "/pass"}, pass, v.exp_pass);
    checkOutput({v.name, "/code"}, fail_code, v.exp_code);
    checkOutput({v.name, "/index"}, fail_index, v.exp_index);
    checkOutput({v.name, "/latency"}, cyc, expLatency(v.exp_code, v.exp_index, v.ack_d, v.rv_d));
    nexp = (v.exp_code == 2'd1) ? 0 : (v.exp_code == 2'd2) ? int'(v.exp_index) + 1 : NW;
    checkOutput({v.name, "/nreq"}, addr_log.size() - log_base, nexp);
    for (int i = 0; i < nexp; i++)
      if (log_base + i < addr_log.size())
        checkOutput($sformatf("%s/addr%0d", v.name, i), addr_log[log_base + i], BASE + 32'(4 * i));
    checkOutput({v.name, "/addr_stable"}, unstable_cnt - unst_base, 0);
    core_halt = 1'b0;
  endtask

  vec_t vecs [8];

  initial begin : main
    int          cyc;
    vec_t        v;
    logic [1:0]  mc;
    logic [31:0] mi;
    rst = 1'b1; start = 1'b0; core_halt = 1'b0;
    vecs[0] = '{"good",       50, 0, 0, 0, 0,  32'h0,    1'b1, 2'd0, 32'd0};
    vecs[1] = '{"rf_r3",      50, 0, 0, 1, 3,  32'h5,    1'b0, 2'd1, 32'd3};
    vecs[2] = '{"dm_w2_slow", 20, 3, 2, 2, 2,  32'h7,    1'b0, 2'd2, 32'd2};
    vecs[3] = '{"good_slow",  5,  1, 1, 0, 0,  32'h0,    1'b1, 2'd0, 32'd0};
    vecs[4] = '{"rf_r0",      1,  0, 0, 1, 0,  32'h1,    1'b0, 2'd1, 32'd0};
    vecs[5] = '{"rf_r31",     8,  2, 0, 1, 31, 32'hDEAD, 1'b0, 2'd1, 32'd31};
    vecs[6] = '{"dm_w0",      3,  0, 3, 2, 0,  32'h15,   1'b0, 2'd2, 32'd0};
    vecs[7] = '{"dm_w3",      12, 2, 1, 2, 3,  32'h0,    1'b0, 2'd2, 32'd3};
    setBaseGold();
    loadData(vecs[0]);
    repeat (3) @(negedge clk);
    checkOutput("rst/busy", busy, 0);
    checkOutput("rst/done", done, 0);
    checkOutput("rst/pass", pass, 0);
    checkOutput("rst/code", fail_code, 0);
    checkOutput("rst/index", fail_index, 0);
    checkOutput("rst/dm_req", dm_req, 0);
    checkOutput("rst/dm_addr", dm_addr, 0);
    checkOutput("rst/rf_raddr", rf_raddr, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      loadData(vecs[i]);
      applyStimulus(vecs[i], 1'b1, -1);
    end

    // Restart from a failed DONE without reset; start pulses while busy must be ignored.
    loadData(vecs[1]);
    applyStimulus(vecs[1], 1'b1, -1);
    loadData(vecs[0]);
    applyStimulus(vecs[0], 1'b0, 10);
    loadData(vecs[3]);
    applyStimulus(vecs[3], 1'b0, 35);

    // Timeout: no halt, 16-cycle instance finishes 16 edges after the start edge.
    doReset();
    loadData(vecs[0]);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!t_done && cyc < 100) begin @(negedge clk); cyc++; end
    checkOutput("to/latency", cyc, 16);
    checkOutput("to/done", t_done, 1);
    checkOutput("to/code", t_fail_code, 3);
    checkOutput("to/pass", t_pass, 0);
    checkOutput("to/index", t_fail_index, 0);
    checkOutput("to/busy", t_busy, 0);
    checkOutput("to/long_still_busy", busy, 1);

    // Halt arriving in the terminal timeout cycle wins.
    doReset();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (15) @(negedge clk);
    core_halt = 1'b1;
    @(negedge clk);
    checkOutput("to_halt/done", t_done, 0);
    checkOutput("to_halt/busy", t_busy, 1);
    checkOutput("to_halt/code", t_fail_code, 0);
    checkOutput("to_halt/rf_raddr", t_rf_raddr, 0);
    repeat (32) @(negedge clk);
    checkOutput("to_halt/dm_req", t_dm_req, 1);
    checkOutput("to_halt/dm_addr", t_dm_addr, BASE);
    core_halt = 1'b0;

    // Reset during a memory wait phase, followed by a stale response.
    doReset();
    loadData(vecs[0]);
    ack_delay = 1; rv_delay = 50;
    cyc = addr_log.size();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; core_halt = 1'b1;
    mi = 0;
    while (!(addr_log.size() == cyc + 1 && !dm_req && busy) && mi < 200) begin @(negedge clk); mi++; end
    checkOutput("mid/in_wait", (addr_log.size() == cyc + 1 && !dm_req && busy), 1);
    rst = 1'b1; core_halt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    late_req++;
    @(negedge clk);
    checkOutput("mid/busy", busy, 0);
    checkOutput("mid/done", done, 0);
    checkOutput("mid/pass", pass, 0);
    checkOutput("mid/code", fail_code, 0);
    checkOutput("mid/index", fail_index, 0);
    checkOutput("mid/dm_req", dm_req, 0);
    checkOutput("mid/dm_addr", dm_addr, 0);
    loadData(vecs[3]);
    applyStimulus(vecs[3], 1'b0, -1);

    // Randomized data, corruption, handshake timing and restart pattern.
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < NR; i++) gold_rf[i] = $urandom;
      for (int i = 0; i < NW; i++) gold_dm[i] = $urandom;
      v.name = $sformatf("rand%0d", n);
      v.halt_delay = $urandom_range(1, 30);
      v.ack_d = $urandom_range(0, 3);
      v.rv_d  = $urandom_range(0, 3);
      v.kind = 0; v.cidx = 0; v.cval = '0;
      loadData(v);
      for (int i = 0; i < NR; i++) if ($urandom_range(0, 15) == 0) rf_mem[i] = rf_mem[i] ^ ($urandom | 32'h1);
      for (int i = 0; i < NW; i++) if ($urandom_range(0, 3) == 0) dm_mem[i] = dm_mem[i] ^ ($urandom | 32'h1);
      refModel(mc, mi);
      v.exp_code = mc; v.exp_index = mi; v.exp_pass = (mc == 2'd0);
      applyStimulus(v, (n % 3 == 0), (n % 4 == 1) ? 12 : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/selfcheck_ctrl.md
Name: selfcheck_ctrl

Overview:
- Sequencer for the on-chip self-check of the RISC-V core.
- Arms on `start` and waits for the core to halt, bounded by a cycle timeout.
- Then walks the register file through its read port and the data memory through a request/response port, one entry at a time, comparing each against expected values.
- Reports a single pass/fail verdict with failure cause and the first mismatching index; sits beside the core in the test top and replaces free-running combinational checking with an ordered, timed scan.

Parameters:
- NUM_REGS, 32, register-file entries scanned (index 0..NUM_REGS-1).
- NUM_WORDS, 4, data-memory words scanned.
- DM_BASE, 32'h00001000, byte address of memory word 0.
- TIMEOUT_CYCLES, 1024, max cycles in WAIT_HALT before timeout fail.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high (compare to common::RESET).
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE.
- core_halt  in  1  level; core finished program.
- rf_raddr  out  5  register-file read index.
- rf_rdata  in  32  combinational read data for rf_raddr.
- exp_rf  in  register_array  expected register values.
- dm_req  out  1  memory read request.
- dm_addr  out  32  byte address, valid while dm_req.
- dm_ack  in  1  request accepted this cycle.
- dm_rvalid  in  1  read data valid.
- dm_rdata  in  32  read data.
- exp_dm  in  memory_array  expected memory words.
- busy  out  1  high in any state except IDLE/DONE.
- done  out  1  high in DONE.
- pass  out  1  valid when done.
- fail_code  out  2  0 none, 1 register mismatch, 2 memory mismatch, 3 timeout.
- fail_index  out  32  first mismatching index; 0 if none.

Behaviour:
- Reset (rst high at clk edge):
  - state IDLE.
  - All outputs 0.
  - Internal counters 0.
  - A pending memory request is abandoned; dm_rvalid arriving after reset is ignored.
- IDLE: start -> WAIT_HALT, timeout counter cleared.
- WAIT_HALT: counter increments each cycle.
  - core_halt -> SCAN_RF with index 0.
  - If counter reaches TIMEOUT_CYCLES-1 without halt -> DONE, fail_code 3.
  - If halt arrives in that same cycle, halt wins.
- SCAN_RF: one entry per cycle; rf_raddr = index.
  - rf_rdata != exp_rf[index] -> DONE, fail_code 1, fail_index = index.
  - At index NUM_REGS-1 with a match -> SCAN_DM, index 0.
- SCAN_DM, issue phase: dm_req=1, dm_addr = DM_BASE + 4*index. Both are held stable until dm_ack, then the block moves to the wait phase.
- SCAN_DM, wait phase: dm_req=0.
  - On dm_rvalid, compare dm_rdata with exp_dm[index].
  - Mismatch -> DONE, fail_code 2, fail_index = index.
  - Match and last index -> DONE, pass=1.
  - Otherwise index+1 -> issue phase.
- Back-to-back responses:
  - dm_ack and dm_rvalid may occur in the same cycle (zero-wait memory); the response is then taken in that cycle.
  - At most one request outstanding.
- DONE:
  - done=1, busy=0; pass and fail outputs held.
  - start -> WAIT_HALT; pass, fail_code and fail_index clear on that edge.
- start in any busy state is ignored.
- Address arithmetic is 32-bit, wrapping modulo 2^32.
- pass=1 only when fail_code=0 and done=1.

Test Plan:
- Good run: start, core_halt after 50 cycles; R1=0x14, R2=0x3, R3=0x2, R4=0x6, others 0; memory words 0x14, 0x3, 0x2, 0x6 -> done with pass=1, fail_code 0, after NUM_REGS rf cycles plus 4 memory transactions.
- Register mismatch: R3 returns 0x5 while expected is 0x2 -> done, fail_code 1, fail_index 3, and no dm_req ever asserted.
- Memory handshake: dm_ack delayed 3 cycles and dm_rvalid 2 further cycles; word 2 = 0x7 -> dm_addr 0x1000, 0x1004, 0x1008 issued in order; dm_addr stable while dm_req is held; fail_code 2, fail_index 2.
- Timeout: core_halt never asserted, TIMEOUT_CYCLES=16 -> done 16 cycles after the start edge, fail_code 3; halt in the terminal cycle instead proceeds to SCAN_RF.
- Reset mid-scan: rst asserted during a memory wait phase, then a late dm_rvalid -> all outputs 0 and state IDLE; a subsequent start runs a clean pass.
- Restart from DONE: after a fail, pulse start (also pulse start while busy) -> the busy pulse is ignored; the restart from DONE clears the flags and the rerun passes.
